dot_life_tracker: RTL and testbench
===================================

# dot_life_tracker

Game-status producer that drives the `anyDotsLeft` and `pacManDied` inputs of the top-level game control FSM and consumes its `resetAll` and `level` outputs. It keeps a per-tile dot bitmap loaded from the level map ROM, clears dots as Pac-Man enters tiles, and tracks remaining dots, score and lives. It sits between the sprite/collision logic and the control FSM.

## Interface
- `X_W`, default 5: tile column index width (32 columns).
- `Y_W`, default 5: tile row index width (32 rows). Number of tiles N = 2^(X_W+Y_W) = 1024.
- `LIVES`, default 3: lives at game start, minimum 1.
- `DOT_PTS`, default 10: score added per dot.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `resetAll` in 1: synchronous level/game restart from the control FSM.
- `level` in 2: 2'b01 selects level 1, 2'b10 selects level 2.
- `map_addr` out 11: map ROM address, `{level[1], tile}` where tile = `{y, x}`.
- `map_dot` in 1: ROM data, valid 1 cycle after `map_addr`.
- `pac_valid` in 1: Pac-Man tile sample is valid this cycle.
- `pac_x` in X_W: Pac-Man tile column.
- `pac_y` in Y_W: Pac-Man tile row.
- `ghost_hit` in 1: one-cycle pulse, ghost collided with Pac-Man.
- `anyDotsLeft` out 1: dots remain, or the block is not yet in PLAY.
- `pacManDied` out 1: one-cycle pulse, last life lost.
- `respawn` out 1: one-cycle pulse, a life was lost with lives remaining.
- `dot_eaten` out 1: one-cycle pulse, a dot was cleared.
- `dots_left` out 11: remaining dot count, 0..1024.
- `score` out 16: accumulated score.
- `lives` out 2: lives remaining.

## Operation
- States are IDLE, SCAN and PLAY.
- Reset values:
  - State is IDLE.
  - Bitmap is all 0; `dots_left` = 0; `score` = 0; `lives` = LIVES.
  - `map_addr` = 0.
  - All pulse outputs are 0.
- IDLE:
  - Entered from reset, or whenever `resetAll` = 1 in any state. `resetAll` has priority over every other input.
  - Holds the scan pointer at 0; `dots_left` = 0.
  - Leaves to SCAN on the first cycle with `resetAll` = 0.
- SCAN:
  - Pointer k runs 0..N-1, one address per cycle; `map_addr` = `{level[1], k}`.
  - `map_dot` returned for address k is written into bitmap[k] one cycle later, and `dots_left` increments when it is 1.
  - After the data for k = N-1 is written, the block enters PLAY.
  - `pac_valid` and `ghost_hit` are ignored.
- PLAY:
  - When `pac_valid` is high and bitmap[{pac_y, pac_x}] = 1: clear the bit, decrement `dots_left`, add DOT_PTS to `score` (saturating at 16'hFFFF), and pulse `dot_eaten`.
  - A sample on an already-clear tile is a no-op.
  - When `ghost_hit` is high and `lives` > 1: decrement `lives` and pulse `respawn`.
  - When `ghost_hit` is high and `lives` = 1: pulse `pacManDied`, reload `lives` to LIVES and clear `score` to 0. The bitmap is left alone; the control FSM reloads it through `resetAll`.
  - A same-cycle eat and hit are both processed. If the hit is fatal, the score clear wins over the dot points.
  - `ghost_hit` is ignored once `dots_left` = 0, so a level that is already beaten cannot also be died.
- `anyDotsLeft` = (state != PLAY) | (`dots_left` != 0). It is driven combinationally from registered state only.
- `score` and `lives` are kept across `resetAll`. Only `reset` and the fatal hit change them outside normal play.

## Timing
- Eat latency: sample at edge t gives `dot_eaten` and the updated `dots_left` after edge t+1. `anyDotsLeft` falls in the same cycle after the last dot is eaten.
- Hit latency: `ghost_hit` at edge t gives `respawn` or `pacManDied` high for exactly the cycle after edge t+1.
- Scan length:
  - `resetAll` falls before edge 0; address 0 is presented in cycle 0.
  - PLAY is entered after edge N+1, i.e. 1026 cycles for N = 1024.
  - `anyDotsLeft` stays 1 throughout IDLE and SCAN.
- `resetAll` mid-SCAN or mid-PLAY: IDLE is entered at the next edge, any pending pulse is dropped, and a fresh scan starts when `resetAll` falls.
- Asynchronous `reset` returns every register to its reset value immediately.

## Test plan
- Map with 3 dots at tiles 0, 5 and 1023 on level 1 → `map_addr[10]` = 0; after 1026 cycles `dots_left` = 3, state PLAY, `anyDotsLeft` = 1 throughout.
- Eat tile 5 twice, then tiles 0 and 1023 → `dot_eaten` pulses 3 times; `score` = 30; `dots_left` goes 2, 1, 0; `anyDotsLeft` falls the cycle after the final eat.
- Three `ghost_hit` pulses with LIVES = 3 → `respawn`, `respawn`, then `pacManDied`; `lives` goes 2, 1, 3; `score` = 0.
- Same-cycle eat of a dot and non-fatal hit → `dot_eaten` and `respawn` both pulse; `score` +10; `lives` -1.
- `resetAll` pulse at scan address 400 → next cycle `dots_left` = 0; rescan restarts at `map_addr` = 0; `score` and `lives` unchanged.
- Level 2 map, `level` = 2'b10 → `map_addr[10]` = 1; `dots_left` matches the level-2 map count; async `reset` mid-play → all outputs at their reset values with no clock edge.

Source files
------------

// File: rtl/dot_life_tracker.sv
// Game-status producer: loads the per-tile dot bitmap from the map ROM, clears dots
// as Pac-Man enters tiles, and tracks remaining dots, score and lives for the control FSM.
module dot_life_tracker #(
    parameter int X_W     = 5,
    parameter int Y_W     = 5,
    parameter int LIVES   = 3,
    parameter int DOT_PTS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               resetAll,
    input  logic [1:0]         level,
    output logic [X_W+Y_W:0]   map_addr,
    input  logic               map_dot,
    input  logic               pac_valid,
    input  logic [X_W-1:0]     pac_x,
    input  logic [Y_W-1:0]     pac_y,
    input  logic               ghost_hit,
    output logic               anyDotsLeft,
    output logic               pacManDied,
    output logic               respawn,
    output logic               dot_eaten,
    output logic [X_W+Y_W:0]   dots_left,
    output logic [15:0]        score,
    output logic [1:0]         lives
);

    localparam int TW = X_W + Y_W;
    localparam int N  = 1 << TW;
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
    localparam logic [TW-1:0] LAST_TILE  = TW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   ptr_q, ptr_d;
    logic            lvl_q, lvl_d;
    logic            a_vld_q, a_vld_d;
    logic            b_vld_q, b_vld_d;
    logic [TW-1:0]   b_idx_q, b_idx_d;
    logic            b_dot_q, b_dot_d;
    logic [N-1:0]    bitmap_q, bitmap_d;
    logic [TW:0]     dots_left_q, dots_left_d;
    logic [15:0]     score_q, score_d;
    logic [1:0]      lives_q, lives_d;
    logic            dot_eaten_q, dot_eaten_d;
    logic            respawn_q, respawn_d;
    logic            died_q, died_d;

    logic [TW-1:0]   pac_idx_s;
    logic            eat_s;
    logic            hit_s;
    logic [16:0]     score_sum_s;
    logic [15:0]     score_add_s;

    // Play-time event decode and saturating score increment.
    always_comb begin
        pac_idx_s   = {pac_y, pac_x};
        eat_s       = pac_valid & bitmap_q[pac_idx_s];
        hit_s       = ghost_hit & (dots_left_q != {(TW+1){1'b0}});
        score_sum_s = {1'b0, score_q} + 17'(DOT_PTS);
        if (score_sum_s[16]) begin
            score_add_s = 16'hFFFF;
        end else begin
            score_add_s = score_sum_s[15:0];
        end
    end

    // Next-state logic: scan pipeline (address -> ROM -> b stage -> bitmap) and play updates.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lvl_d       = lvl_q;
        a_vld_d     = a_vld_q;
        b_vld_d     = 1'b0;
        b_idx_d     = b_idx_q;
        b_dot_d     = b_dot_q;
        bitmap_d    = bitmap_q;
        dots_left_d = dots_left_q;
        score_d     = score_q;
        lives_d     = lives_q;
        dot_eaten_d = 1'b0;
        respawn_d   = 1'b0;
        died_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Undefined level codes fall back to the level-1 map.
                lvl_d       = level[1] & ~level[0];
                dots_left_d = {(TW+1){1'b0}};
                ptr_d       = {TW{1'b0}};
                a_vld_d     = 1'b0;
                if (!resetAll) begin
                    state_d = S_SCAN;
                    ptr_d   = TW'(1);
                    a_vld_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                b_vld_d = a_vld_q;
                b_idx_d = ptr_q - TW'(1);
                b_dot_d = map_dot;
                a_vld_d = a_vld_q & (ptr_q != {TW{1'b0}});
                if (ptr_q != {TW{1'b0}}) begin
                    ptr_d = ptr_q + TW'(1);
                end else begin
                    ptr_d = {TW{1'b0}};
                end
                if (b_vld_q) begin
                    bitmap_d[b_idx_q] = b_dot_q;
                    if (b_dot_q) begin
                        dots_left_d = dots_left_q + (TW+1)'(1);
                    end else begin
                        dots_left_d = dots_left_q;
                    end
                    if (b_idx_q == LAST_TILE) begin
                        state_d = S_PLAY;
                    end else begin
                        state_d = S_SCAN;
                    end
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_PLAY: begin
                if (eat_s) begin
                    bitmap_d[pac_idx_s] = 1'b0;
                    dots_left_d         = dots_left_q - (TW+1)'(1);
                    score_d             = score_add_s;
                    dot_eaten_d         = 1'b1;
                end else begin
                    dot_eaten_d = 1'b0;
                end
                // A fatal hit's score clear overrides any same-cycle dot points.
                if (hit_s) begin
                    if (lives_q > 2'd1) begin
                        lives_d   = lives_q - 2'd1;
                        respawn_d = 1'b1;
                    end else begin
                        lives_d = LIVES_INIT;
                        score_d = 16'd0;
                        died_d  = 1'b1;
                    end
                end else begin
                    lives_d = lives_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (resetAll) begin
            state_d     = S_IDLE;
            lvl_d       = level[1] & ~level[0];
            ptr_d       = {TW{1'b0}};
            a_vld_d     = 1'b0;
            b_vld_d     = 1'b0;
            bitmap_d    = bitmap_q;
            dots_left_d = {(TW+1){1'b0}};
            score_d     = score_q;
            lives_d     = lives_q;
            dot_eaten_d = 1'b0;
            respawn_d   = 1'b0;
            died_d      = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= {TW{1'b0}};
            lvl_q       <= 1'b0;
            a_vld_q     <= 1'b0;
            b_vld_q     <= 1'b0;
            b_idx_q     <= {TW{1'b0}};
            b_dot_q     <= 1'b0;
            bitmap_q    <= {N{1'b0}};
            dots_left_q <= {(TW+1){1'b0}};
            score_q     <= 16'd0;
            lives_q     <= LIVES_INIT;
            dot_eaten_q <= 1'b0;
            respawn_q   <= 1'b0;
            died_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lvl_q       <= lvl_d;
            a_vld_q     <= a_vld_d;
            b_vld_q     <= b_vld_d;
            b_idx_q     <= b_idx_d;
            b_dot_q     <= b_dot_d;
            bitmap_q    <= bitmap_d;
            dots_left_q <= dots_left_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            dot_eaten_q <= dot_eaten_d;
            respawn_q   <= respawn_d;
            died_q      <= died_d;
        end
    end

    assign map_addr    = {lvl_q, ptr_q};
    assign anyDotsLeft = (state_q != S_PLAY) | (dots_left_q != {(TW+1){1'b0}});
    assign pacManDied  = died_q;
    assign respawn     = respawn_q;
    assign dot_eaten   = dot_eaten_q;
    assign dots_left   = dots_left_q;
    assign score       = score_q;
    assign lives       = lives_q;

endmodule

// File: tb/tb_dot_life_tracker.sv
// Directed bench for dot_life_tracker: scripted map ROM, scan, eat, hit, restart and reset vectors.
module tb_dot_life_tracker;

    logic        clk;
    logic        reset;
    logic        resetAll;
    logic [1:0]  level;
    logic [10:0] map_addr;
    logic        map_dot;
    logic        pac_valid;
    logic [4:0]  pac_x;
    logic [4:0]  pac_y;
    logic        ghost_hit;
    logic        anyDotsLeft;
    logic        pacManDied;
    logic        respawn;
    logic        dot_eaten;
    logic [10:0] dots_left;
    logic [15:0] score;
    logic [1:0]  lives;

    int n_total = 0;
    int n_bad   = 0;

    dot_life_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .resetAll   (resetAll),
        .level      (level),
        .map_addr   (map_addr),
        .map_dot    (map_dot),
        .pac_valid  (pac_valid),
        .pac_x      (pac_x),
        .pac_y      (pac_y),
        .ghost_hit  (ghost_hit),
        .anyDotsLeft(anyDotsLeft),
        .pacManDied (pacManDied),
        .respawn    (respawn),
        .dot_eaten  (dot_eaten),
        .dots_left  (dots_left),
        .score      (score),
        .lives      (lives)
    );

    always #5 clk = ~clk;

    // Level 1: dots at tiles 0, 5, 1023. Level 2: dots at tiles 1, 2, 3, 100, 512.
    function automatic logic rom_bit(input logic [10:0] a);
        case (a)
            11'd0, 11'd5, 11'd1023:                        rom_bit = 1'b1;
            11'd1025, 11'd1026, 11'd1027, 11'd1124, 11'd1536: rom_bit = 1'b1;
            default:                                       rom_bit = 1'b0;
        endcase
    endfunction

    always @(posedge clk) map_dot <= rom_bit(map_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic pv, input logic [4:0] x, input logic [4:0] y, input logic gh);
        pac_valid = pv;
        pac_x     = x;
        pac_y     = y;
        ghost_hit = gh;
        tick();
        pac_valid = 1'b0;
        ghost_hit = 1'b0;
    endtask

    // Runs n cycles and reports whether anyDotsLeft stayed high throughout.
    task automatic run_scan(input int n, output logic adl_ok);
        adl_ok = 1'b1;
        for (int c = 0; c < n; c++) begin
            tick();
            if (anyDotsLeft !== 1'b1) adl_ok = 1'b0;
        end
    endtask

    logic ok;

    initial begin
        clk = 1'b0; reset = 1'b1; resetAll = 1'b1; level = 2'b01;
        pac_valid = 1'b0; pac_x = 5'd0; pac_y = 5'd0; ghost_hit = 1'b0; map_dot = 1'b0;
        @(negedge clk);
        chk("rst_dots", 32'(dots_left), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_addr", 32'(map_addr), 32'd0);
        chk("rst_adl", 32'(anyDotsLeft), 32'd1);
        chk("rst_pulses", 32'({dot_eaten, respawn, pacManDied}), 32'd0);
        reset = 1'b0;
        tick(); tick();

        // Level-1 scan: cycle 0 presents address 0.
        resetAll = 1'b0;
        chk("l1_addr0", 32'(map_addr), 32'd0);
        run_scan(400, ok);
        chk("l1_addr400", 32'(map_addr), 32'd400);
        chk("l1_adl_scan", 32'(ok), 32'd1);
        run_scan(625, ok);
        chk("l1_dots_e1024", 32'(dots_left), 32'd2);
        tick();
        chk("l1_dots_e1025", 32'(dots_left), 32'd3);
        chk("l1_adl_play", 32'(anyDotsLeft), 32'd1);

        // Eat sequence.
        step(1'b1, 5'd5, 5'd0, 1'b0);
        chk("eat5_pulse", 32'(dot_eaten), 32'd1);
        chk("eat5_dots", 32'(dots_left), 32'd2);
        chk("eat5_score", 32'(score), 32'd10);
        step(1'b1, 5'd5, 5'd0, 1'b0);
        chk("eat5b_pulse", 32'(dot_eaten), 32'd0);
        chk("eat5b_dots", 32'(dots_left), 32'd2);
        chk("eat5b_score", 32'(score), 32'd10);
        step(1'b1, 5'd0, 5'd0, 1'b0);
        chk("eat0_dots", 32'(dots_left), 32'd1);
        chk("eat0_adl", 32'(anyDotsLeft), 32'd1);
        step(1'b1, 5'd31, 5'd31, 1'b0);
        chk("eat1023_pulse", 32'(dot_eaten), 32'd1);
        chk("eat1023_dots", 32'(dots_left), 32'd0);
        chk("eat1023_adl", 32'(anyDotsLeft), 32'd0);
        chk("eat1023_score", 32'(score), 32'd30);
        tick();
        chk("eat_pulse_end", 32'(dot_eaten), 32'd0);

        // Hit after the level is cleared is ignored.
        step(1'b0, 5'd0, 5'd0, 1'b1);
        chk("hit_cleared_resp", 32'(respawn), 32'd0);
        chk("hit_cleared_lives", 32'(lives), 32'd3);

        // Restart, then abort the rescan at address 400.
        resetAll = 1'b1;
        tick();
        chk("ra_adl", 32'(anyDotsLeft), 32'd1);
        resetAll = 1'b0;
        run_scan(400, ok);
        chk("ra_mid_dots", 32'(dots_left), 32'd2);
        resetAll = 1'b1;
        tick();
        chk("ra400_dots", 32'(dots_left), 32'd0);
        chk("ra400_score", 32'(score), 32'd30);
        chk("ra400_lives", 32'(lives), 32'd3);
        resetAll = 1'b0;
        chk("ra400_addr", 32'(map_addr), 32'd0);
        run_scan(1026, ok);
        chk("rescan_dots", 32'(dots_left), 32'd3);
        chk("rescan_adl", 32'(ok), 32'd1);

        // Same-cycle eat and non-fatal hit, then down to the fatal hit.
        step(1'b1, 5'd5, 5'd0, 1'b1);
        chk("combo_eat", 32'(dot_eaten), 32'd1);
        chk("combo_resp", 32'(respawn), 32'd1);
        chk("combo_score", 32'(score), 32'd40);
        chk("combo_lives", 32'(lives), 32'd2);
        chk("combo_dots", 32'(dots_left), 32'd2);
        tick();
        chk("resp_end", 32'(respawn), 32'd0);
        step(1'b0, 5'd0, 5'd0, 1'b1);
        chk("hit2_resp", 32'(respawn), 32'd1);
        chk("hit2_lives", 32'(lives), 32'd1);
        chk("hit2_died", 32'(pacManDied), 32'd0);
        step(1'b1, 5'd0, 5'd0, 1'b1);
        chk("hit3_died", 32'(pacManDied), 32'd1);
        chk("hit3_resp", 32'(respawn), 32'd0);
        chk("hit3_eat", 32'(dot_eaten), 32'd1);
        chk("hit3_lives", 32'(lives), 32'd3);
        chk("hit3_score", 32'(score), 32'd0);
        chk("hit3_dots", 32'(dots_left), 32'd1);
        tick();
        chk("died_end", 32'(pacManDied), 32'd0);

        // Level 2 map.
        level = 2'b10;
        resetAll = 1'b1;
        tick(); tick();
        resetAll = 1'b0;
        chk("l2_addr0", 32'(map_addr), 32'h400);
        run_scan(1026, ok);
        chk("l2_dots", 32'(dots_left), 32'd5);
        step(1'b1, 5'd1, 5'd0, 1'b0);
        chk("l2_eat_dots", 32'(dots_left), 32'd4);
        chk("l2_eat_pulse", 32'(dot_eaten), 32'd1);
        chk("l2_eat_score", 32'(score), 32'd10);

        // Asynchronous reset mid-cycle, no clock edge.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_dots", 32'(dots_left), 32'd0);
        chk("arst_score", 32'(score), 32'd0);
        chk("arst_lives", 32'(lives), 32'd3);
        chk("arst_addr", 32'(map_addr), 32'd0);
        chk("arst_eat", 32'(dot_eaten), 32'd0);
        chk("arst_adl", 32'(anyDotsLeft), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
